// File: rtl/branch_ctrl_pkg.sv
// Shared CPU defines for branch control: opcodes, REGIMM rt codes, pc_sel
// encodings, FSM state encoding and small decode helpers.
package branch_ctrl_pkg;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SLOT = 2'd2
  } state_t;

  function automatic logic is_branch_op(input logic [5:0] op, input logic [4:0] rt);
    logic hit;
    hit = 1'b0;
    case (op)
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: hit = 1'b1;
      OP_REGIMM: hit = (rt == RT_BLTZ) || (rt == RT_BGEZ) ||
                       (rt == RT_BLTZAL) || (rt == RT_BGEZAL);
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic is_jump_op(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

  function automatic logic uses_rt_op(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/branch_ctrl_hazard.sv
// branch_hazard: combinational operand-use, hazard and MEM-forward detection
// for the branch comparator operands.
module branch_hazard
  import branch_ctrl_pkg::*;
(
  input  logic       id_valid,
  input  logic [5:0] id_op,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_regwrite,
  input  logic [4:0] ex_writereg,
  input  logic       mem_regwrite,
  input  logic       mem_memtoreg,
  input  logic [4:0] mem_writereg,
  output logic       hazard,
  output logic       fwd_a,
  output logic       fwd_b
);

  logic use_rs, use_rt;
  logic ex_hit_rs, ex_hit_rt;
  logic ld_hit_rs, ld_hit_rt;
  logic alu_hit_rs, alu_hit_rt;

  assign use_rs = id_valid && is_branch_op(id_op, id_rt);
  assign use_rt = use_rs && uses_rt_op(id_op);

  // r0 is hardwired to zero, so it can never be a hazard or forward source.
  assign ex_hit_rs  = ex_regwrite && (ex_writereg == id_rs) && (id_rs != 5'd0);
  assign ex_hit_rt  = ex_regwrite && (ex_writereg == id_rt) && (id_rt != 5'd0);
  assign ld_hit_rs  = mem_memtoreg && (mem_writereg == id_rs) && (id_rs != 5'd0);
  assign ld_hit_rt  = mem_memtoreg && (mem_writereg == id_rt) && (id_rt != 5'd0);
  assign alu_hit_rs = mem_regwrite && !mem_memtoreg && (mem_writereg == id_rs) && (id_rs != 5'd0);
  assign alu_hit_rt = mem_regwrite && !mem_memtoreg && (mem_writereg == id_rt) && (id_rt != 5'd0);

  assign hazard = (use_rs && (ex_hit_rs || ld_hit_rs)) ||
                  (use_rt && (ex_hit_rt || ld_hit_rt));

  // A younger EX write shadows the MEM result, so forwarding yields to it.
  assign fwd_a = alu_hit_rs && !ex_hit_rs;
  assign fwd_b = alu_hit_rt && !ex_hit_rt;

endmodule

// File: rtl/branch_ctrl.sv
// Branch/jump control FSM with delay-slot tracking. Optional performance
// counters are built only when BRANCH_PERF_EN is defined.
//
// state | meaning
// IDLE  | no branch pending
// WAIT  | branch held in ID by an operand hazard
// SLOT  | next ID instruction is the delay slot
module branch_ctrl
  import branch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        id_valid,
  input  logic [5:0]  id_op,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_regwrite,
  input  logic [4:0]  ex_writereg,
  input  logic        mem_regwrite,
  input  logic        mem_memtoreg,
  input  logic [4:0]  mem_writereg,
  input  logic        cmp_y,
  output logic [5:0]  cmp_op,
  output logic [4:0]  cmp_rt,
  output logic        fwd_a,
  output logic        fwd_b,
  output logic        stall_id,
  output logic [1:0]  pc_sel,
  output logic        flush_ex,
  output logic        in_delay_slot,
  output logic        ds_branch_err,
  output logic [31:0] perf_br,
  output logic [31:0] perf_taken,
  output logic [31:0] perf_stall
);

  state_t state_q, state_d;
  logic   hazard, fwd_a_raw, fwd_b_raw;
  logic   is_branch, is_jump, resolve;

  branch_hazard u_hazard (
    .id_valid     (id_valid),
    .id_op        (id_op),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_regwrite  (ex_regwrite),
    .ex_writereg  (ex_writereg),
    .mem_regwrite (mem_regwrite),
    .mem_memtoreg (mem_memtoreg),
    .mem_writereg (mem_writereg),
    .hazard       (hazard),
    .fwd_a        (fwd_a_raw),
    .fwd_b        (fwd_b_raw)
  );

  assign cmp_op    = id_op;
  assign cmp_rt    = id_rt;
  assign is_branch = id_valid && is_branch_op(id_op, id_rt);
  assign is_jump   = id_valid && is_jump_op(id_op);

  assign fwd_a         = !rst && fwd_a_raw;
  assign fwd_b         = !rst && fwd_b_raw;
  assign in_delay_slot = !rst && (state_q == ST_SLOT);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Reset and the global stall both leave every control output at zero.
  always_comb begin
    state_d       = state_q;
    pc_sel        = PC_SEL_SEQ;
    stall_id      = 1'b0;
    flush_ex      = 1'b0;
    ds_branch_err = 1'b0;
    resolve       = 1'b0;
    if (!rst && !stall_in) begin
      case (state_q)
        ST_IDLE: begin
          if (is_branch) begin
            if (hazard) begin
              stall_id = 1'b1;
              flush_ex = 1'b1;
              state_d  = ST_WAIT;
            end else begin
              resolve = 1'b1;
              state_d = ST_SLOT;
            end
          end else if (is_jump) begin
            pc_sel  = PC_SEL_JUMP;
            state_d = ST_SLOT;
          end
        end
        ST_WAIT: begin
          if (hazard) begin
            stall_id = 1'b1;
            flush_ex = 1'b1;
          end else begin
            resolve = 1'b1;
            state_d = ST_SLOT;
          end
        end
        ST_SLOT: begin
          if (id_valid) begin
            ds_branch_err = is_branch || is_jump;
            state_d       = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (resolve) pc_sel = cmp_y ? PC_SEL_BRANCH : PC_SEL_SEQ;
    end
  end

`ifdef BRANCH_PERF_EN
  logic [31:0] perf_br_q, perf_taken_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_br_q    <= 32'd0;
      perf_taken_q <= 32'd0;
      perf_stall_q <= 32'd0;
    end else if (!stall_in) begin
      if (resolve && (perf_br_q != 32'hFFFF_FFFF))
        perf_br_q <= perf_br_q + 32'd1;
      if (resolve && cmp_y && (perf_taken_q != 32'hFFFF_FFFF))
        perf_taken_q <= perf_taken_q + 32'd1;
      if ((state_q == ST_WAIT) && (perf_stall_q != 32'hFFFF_FFFF))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_br    = perf_br_q;
  assign perf_taken = perf_taken_q;
  assign perf_stall = perf_stall_q;
`else
  assign perf_br    = 32'd0;
  assign perf_taken = 32'd0;
  assign perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: IDLE-state vector table, directed
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_branch_ctrl;

`ifdef BRANCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_in = 1'b0, id_valid = 1'b0;
  logic [5:0]  id_op = '0;
  logic [4:0]  id_rs = '0, id_rt = '0;
  logic        ex_regwrite = 1'b0, mem_regwrite = 1'b0, mem_memtoreg = 1'b0, cmp_y = 1'b0;
  logic [4:0]  ex_writereg = '0, mem_writereg = '0;
  logic [5:0]  cmp_op;
  logic [4:0]  cmp_rt;
  logic        fwd_a, fwd_b, stall_id, flush_ex, in_delay_slot, ds_branch_err;
  logic [1:0]  pc_sel;
  logic [31:0] perf_br, perf_taken, perf_stall;

  int n_cmp = 0;
  int n_fail = 0;

  branch_ctrl dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .id_valid(id_valid), .id_op(id_op),
    .id_rs(id_rs), .id_rt(id_rt), .ex_regwrite(ex_regwrite), .ex_writereg(ex_writereg),
    .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg), .mem_writereg(mem_writereg),
    .cmp_y(cmp_y), .cmp_op(cmp_op), .cmp_rt(cmp_rt), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_id(stall_id), .pc_sel(pc_sel), .flush_ex(flush_ex), .in_delay_slot(in_delay_slot),
    .ds_branch_err(ds_branch_err), .perf_br(perf_br), .perf_taken(perf_taken),
    .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drv(input logic v, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                     input logic exw, input logic [4:0] exr, input logic mrw, input logic mm,
                     input logic [4:0] mr, input logic cy, input logic st);
    id_valid = v; id_op = op; id_rs = rs; id_rt = rt;
    ex_regwrite = exw; ex_writereg = exr;
    mem_regwrite = mrw; mem_memtoreg = mm; mem_writereg = mr;
    cmp_y = cy; stall_in = st;
  endtask

  task automatic nop();
    drv(1'b1, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Leaves the bench at a falling edge with rst low and the DUT freshly reset.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    nop();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_ctl(input string tag, input logic [1:0] pc, input logic st, input logic fl,
                         input logic ds, input logic err);
    chk({tag, ".pc_sel"}, {30'd0, pc_sel}, {30'd0, pc});
    chk({tag, ".stall_id"}, {31'd0, stall_id}, {31'd0, st});
    chk({tag, ".flush_ex"}, {31'd0, flush_ex}, {31'd0, fl});
    chk({tag, ".in_delay_slot"}, {31'd0, in_delay_slot}, {31'd0, ds});
    chk({tag, ".ds_branch_err"}, {31'd0, ds_branch_err}, {31'd0, err});
  endtask

  task automatic chk_perf(input string tag, input int br, input int tk, input int sl);
    chk({tag, ".perf_br"}, perf_br, PERF ? br : 0);
    chk({tag, ".perf_taken"}, perf_taken, PERF ? tk : 0);
    chk({tag, ".perf_stall"}, perf_stall, PERF ? sl : 0);
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic bit m_branch(bit v, logic [5:0] op, logic [4:0] rt);
    logic [5:0] brs [4] = '{6'd4, 6'd5, 6'd6, 6'd7};
    logic [4:0] rim [4] = '{5'd0, 5'd1, 5'd16, 5'd17};
    if (!v) return 1'b0;
    foreach (brs[i]) if (op == brs[i]) return 1'b1;
    if (op == 6'd1) foreach (rim[i]) if (rt == rim[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_reg_busy(logic [4:0] r);
    if (r == 0) return 1'b0;
    return (ex_regwrite && ex_writereg == r) || (mem_memtoreg && mem_writereg == r);
  endfunction

  function automatic bit m_fwd(logic [4:0] r);
    if (r == 0) return 1'b0;
    if (ex_regwrite && ex_writereg == r) return 1'b0;
    return mem_regwrite && !mem_memtoreg && mem_writereg == r;
  endfunction

  bit m_wait, m_slot;
  longint m_br, m_tk, m_st;

  typedef struct {
    logic v; logic [5:0] op; logic [4:0] rs, rt;
    logic exw; logic [4:0] exr; logic mrw, mm; logic [4:0] mr; logic cy, st;
    logic [1:0] e_pc; logic e_stall, e_flush, e_fa, e_fb;
  } vec_t;

  vec_t tbl [14];

  initial begin
    // reset state
    @(negedge clk); #1;
    chk_ctl("reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_perf("reset", 0, 0, 0);

    // IDLE-state single-cycle vectors
    tbl[0]  = '{1, 6'd0,  5'd1, 5'd2, 0, 5'd0, 0, 0, 5'd0, 1, 0, 2'b00, 0, 0, 0, 0};
    tbl[1]  = '{1, 6'd4,  5'd1, 5'd2, 0, 5'd0, 0, 0, 5'd0, 1, 0, 2'b01, 0, 0, 0, 0};
    tbl[2]  = '{1, 6'd4,  5'd1, 5'd2, 0, 5'd0, 0, 0, 5'd0, 0, 0, 2'b00, 0, 0, 0, 0};
    tbl[3]  = '{1, 6'd4,  5'd1, 5'd2, 1, 5'd2, 0, 0, 5'd0, 1, 0, 2'b00, 1, 1, 0, 0};
    tbl[4]  = '{1, 6'd6,  5'd1, 5'd2, 1, 5'd2, 0, 0, 5'd0, 1, 0, 2'b01, 0, 0, 0, 0};
    tbl[5]  = '{1, 6'd7,  5'd3, 5'd0, 0, 5'd0, 1, 1, 5'd3, 1, 0, 2'b00, 1, 1, 0, 0};
    tbl[6]  = '{1, 6'd4,  5'd3, 5'd4, 0, 5'd0, 1, 0, 5'd4, 1, 0, 2'b01, 0, 0, 0, 1};
    tbl[7]  = '{1, 6'd5,  5'd6, 5'd7, 1, 5'd6, 1, 0, 5'd6, 1, 0, 2'b00, 1, 1, 0, 0};
    tbl[8]  = '{1, 6'd2,  5'd1, 5'd2, 0, 5'd0, 0, 0, 5'd0, 0, 0, 2'b10, 0, 0, 0, 0};
    tbl[9]  = '{1, 6'd3,  5'd1, 5'd2, 0, 5'd0, 0, 0, 5'd0, 0, 1, 2'b00, 0, 0, 0, 0};
    tbl[10] = '{1, 6'd1,  5'd1, 5'd2, 0, 5'd0, 0, 0, 5'd0, 1, 0, 2'b00, 0, 0, 0, 0};
    tbl[11] = '{0, 6'd4,  5'd1, 5'd2, 0, 5'd0, 0, 0, 5'd0, 1, 0, 2'b00, 0, 0, 0, 0};
    tbl[12] = '{1, 6'd4,  5'd0, 5'd0, 0, 5'd0, 1, 0, 5'd0, 1, 0, 2'b01, 0, 0, 0, 0};
    tbl[13] = '{1, 6'd1,  5'd4, 5'd16, 1, 5'd4, 1, 0, 5'd5, 1, 1, 2'b00, 0, 0, 0, 0};
    for (int i = 0; i < 14; i++) begin
      do_reset();
      drv(tbl[i].v, tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].exw, tbl[i].exr,
          tbl[i].mrw, tbl[i].mm, tbl[i].mr, tbl[i].cy, tbl[i].st);
      #1;
      chk($sformatf("vec%0d.pc_sel", i), {30'd0, pc_sel}, {30'd0, tbl[i].e_pc});
      chk($sformatf("vec%0d.stall_id", i), {31'd0, stall_id}, {31'd0, tbl[i].e_stall});
      chk($sformatf("vec%0d.flush_ex", i), {31'd0, flush_ex}, {31'd0, tbl[i].e_flush});
      chk($sformatf("vec%0d.fwd_a", i), {31'd0, fwd_a}, {31'd0, tbl[i].e_fa});
      chk($sformatf("vec%0d.fwd_b", i), {31'd0, fwd_b}, {31'd0, tbl[i].e_fb});
      chk($sformatf("vec%0d.cmp_op", i), {26'd0, cmp_op}, {26'd0, tbl[i].op});
      chk($sformatf("vec%0d.cmp_rt", i), {27'd0, cmp_rt}, {27'd0, tbl[i].rt});
    end

    // beq taken, no hazard
    do_reset();
    drv(1, 6'd4, 5'd3, 5'd4, 0, 5'd0, 0, 0, 5'd0, 1, 0); #1;
    chk_ctl("beq_tk", 2'b01, 0, 0, 0, 0);
    @(negedge clk); nop(); #1;
    chk_ctl("beq_tk.slot", 2'b00, 0, 0, 1, 0);
    chk_perf("beq_tk", 1, 1, 0);
    @(negedge clk); nop(); #1;
    chk_ctl("beq_tk.after", 2'b00, 0, 0, 0, 0);

    // bne with EX hazard then MEM load hazard
    do_reset();
    drv(1, 6'd5, 5'd5, 5'd9, 1, 5'd5, 0, 0, 5'd0, 0, 0); #1;
    chk_ctl("bne_h1", 2'b00, 1, 1, 0, 0);
    @(negedge clk); drv(1, 6'd5, 5'd5, 5'd9, 0, 5'd0, 1, 1, 5'd5, 0, 0); #1;
    chk_ctl("bne_h2", 2'b00, 1, 1, 0, 0);
    @(negedge clk); drv(1, 6'd5, 5'd5, 5'd9, 0, 5'd0, 0, 0, 5'd0, 0, 0); #1;
    chk_ctl("bne_res", 2'b00, 0, 0, 0, 0);
    @(negedge clk); nop(); #1;
    chk_ctl("bne_slot", 2'b00, 0, 0, 1, 0);
    chk_perf("bne", 1, 0, 2);

    // bgez on r0 ignores EX write to r0
    do_reset();
    drv(1, 6'd1, 5'd0, 5'd1, 1, 5'd0, 0, 0, 5'd0, 1, 0); #1;
    chk_ctl("bgez_r0", 2'b01, 0, 0, 0, 0);

    // jump then branch in delay slot
    do_reset();
    drv(1, 6'd2, 5'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 0); #1;
    chk_ctl("j", 2'b10, 0, 0, 0, 0);
    @(negedge clk); drv(1, 6'd4, 5'd1, 5'd2, 0, 5'd0, 0, 0, 5'd0, 1, 0); #1;
    chk_ctl("j.ds_beq", 2'b00, 0, 0, 1, 1);
    @(negedge clk); nop(); #1;
    chk_ctl("j.after", 2'b00, 0, 0, 0, 0);
    chk_perf("j", 0, 0, 0);

    // WAIT frozen by global stall, then reset mid-WAIT
    do_reset();
    drv(1, 6'd4, 5'd2, 5'd3, 1, 5'd2, 0, 0, 5'd0, 1, 0); #1;
    chk_ctl("hold.h", 2'b00, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); stall_in = 1'b1; #1;
      chk_ctl($sformatf("hold.st%0d", i), 2'b00, 0, 0, 0, 0);
      chk_perf($sformatf("hold.st%0d", i), 0, 0, 0);
    end
    @(negedge clk); stall_in = 1'b0; #1;
    chk_ctl("hold.resume", 2'b00, 1, 1, 0, 0);
    @(negedge clk); rst = 1'b1; mem_regwrite = 1'b1; mem_writereg = 5'd3; #1;
    chk_ctl("hold.rst", 2'b00, 0, 0, 0, 0);
    chk("hold.rst.fwd_b", {31'd0, fwd_b}, 32'd0);
    @(negedge clk); rst = 1'b0; nop(); #1;
    chk_ctl("hold.after", 2'b00, 0, 0, 0, 0);
    chk_perf("hold.after", 0, 0, 0);

    // randomized traffic against the model
    do_reset();
    m_wait = 0; m_slot = 0; m_br = 0; m_tk = 0; m_st = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [5:0] ops [9] = '{6'd0, 6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd2, 6'd3, 6'd35};
      logic [4:0] rims [5] = '{5'd0, 5'd1, 5'd16, 5'd17, 5'd2};
      bit br, jmp, haz;
      logic [1:0] e_pc;
      bit e_st, e_fl, e_err;
      @(negedge clk);
      if (!m_wait) begin
        id_valid = ($urandom_range(0, 7) != 0);
        id_op = ops[$urandom_range(0, 8)];
        id_rs = 5'($urandom_range(0, 7));
        id_rt = (id_op == 6'd1) ? rims[$urandom_range(0, 4)] : 5'($urandom_range(0, 7));
      end
      ex_regwrite = $urandom_range(0, 1); ex_writereg = 5'($urandom_range(0, 7));
      mem_regwrite = $urandom_range(0, 1); mem_memtoreg = ($urandom_range(0, 2) == 0);
      mem_writereg = 5'($urandom_range(0, 7));
      cmp_y = $urandom_range(0, 1);
      stall_in = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 49) == 0);
      #1;
      br  = m_branch(id_valid, id_op, id_rt);
      jmp = id_valid && (id_op == 6'd2 || id_op == 6'd3);
      haz = br && (m_reg_busy(id_rs) || ((id_op == 6'd4 || id_op == 6'd5) && m_reg_busy(id_rt)));
      e_pc = 2'b00; e_st = 0; e_fl = 0; e_err = 0;
      if (!rst && !stall_in) begin
        if (m_slot) e_err = br || jmp;
        else if (m_wait || br) begin
          if (haz) begin e_st = 1; e_fl = 1; end
          else e_pc = cmp_y ? 2'b01 : 2'b00;
        end else if (jmp) e_pc = 2'b10;
      end
      chk_ctl("rnd", e_pc, e_st, e_fl, !rst && m_slot, e_err);
      chk("rnd.fwd_a", {31'd0, fwd_a}, {31'd0, !rst && m_fwd(id_rs)});
      chk("rnd.fwd_b", {31'd0, fwd_b}, {31'd0, !rst && m_fwd(id_rt)});
      chk("rnd.cmp_op", {26'd0, cmp_op}, {26'd0, id_op});
      chk("rnd.perf_br", perf_br, PERF ? 32'(m_br) : 32'd0);
      chk("rnd.perf_taken", perf_taken, PERF ? 32'(m_tk) : 32'd0);
      chk("rnd.perf_stall", perf_stall, PERF ? 32'(m_st) : 32'd0);
      if (rst) begin
        m_wait = 0; m_slot = 0; m_br = 0; m_tk = 0; m_st = 0;
      end else if (!stall_in) begin
        if (m_slot) begin
          if (id_valid) m_slot = 0;
        end else if (m_wait || br) begin
          if (m_wait && m_st < 64'hFFFF_FFFF) m_st++;
          if (haz) m_wait = 1;
          else begin
            m_wait = 0; m_slot = 1;
            if (m_br < 64'hFFFF_FFFF) m_br++;
            if (cmp_y && m_tk < 64'hFFFF_FFFF) m_tk++;
          end
        end else if (jmp) m_slot = 1;
      end
    end

`ifdef BRANCH_PERF_EN
    // saturation of perf_taken
    do_reset();
    dut.perf_taken_q = 32'hFFFF_FFFF;
    drv(1, 6'd4, 5'd3, 5'd4, 0, 5'd0, 0, 0, 5'd0, 1, 0); #1;
    chk_ctl("sat", 2'b01, 0, 0, 0, 0);
    @(negedge clk); nop(); #1;
    chk("sat.perf_taken", perf_taken, 32'hFFFF_FFFF);
    chk("sat.perf_br", perf_br, 32'd1);
`else
    do_reset();
    drv(1, 6'd4, 5'd3, 5'd4, 0, 5'd0, 0, 0, 5'd0, 1, 0); #1;
    @(negedge clk); nop(); #1;
    chk_perf("noperf", 0, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 The block SHALL have these ports:
- stall_in  in  1  global pipeline stall from the caches.
- id_valid  in  1  ID-stage instruction valid.
- id_op  in  6  ID opcode.
- id_rs / id_rt  in  5 each  ID source register numbers.
- ex_regwrite  in  1  EX-stage instruction writes a register.
- ex_writereg  in  5  EX-stage destination register.
- mem_regwrite  in  1  MEM-stage instruction writes a register.
- mem_memtoreg  in  1  MEM-stage instruction is a load.
- mem_writereg  in  5  MEM-stage destination register.
- cmp_y  in  1  comparator decision.
- cmp_op  out  6  opcode driven to the comparator.
- cmp_rt  out  5  rt driven to the comparator.
- fwd_a / fwd_b  out  1 each  select the MEM ALU result for comparator operand a / b.
- stall_id  out  1  hold IF/ID.
- pc_sel  out  2  00 = pc+4, 01 = branch target, 10 = jump target.
- flush_ex  out  1  insert a bubble into ID/EX.
- in_delay_slot  out  1  the current ID instruction is a delay slot.
- ds_branch_err  out  1  a branch was found in a delay slot.
- perf_br / perf_taken / perf_stall  out  32 each  performance counters.

Function
REQ-003 Branch set: beq 000100, bne 000101, blez 000110, bgtz 000111, REGIMM 000001 with rt in {00000, 00001, 10000, 10001}. Jump set: j 000010, jal 000011.
REQ-004 cmp_op and cmp_rt SHALL equal id_op and id_rt combinationally at all times.
REQ-005 Operand use: rs is used by every branch; rt is used only by beq and bne.
REQ-006 A hazard SHALL exist on a used source register r != 0 under either condition:
- (ex_regwrite and ex_writereg == r), or
- (mem_memtoreg and mem_writereg == r).
REQ-007 fwd_a / fwd_b SHALL be 1 when mem_regwrite, not mem_memtoreg, mem_writereg == rs / rt, that register is nonzero, and no EX hazard exists on the same register.
REQ-008 The FSM SHALL have three states:
- IDLE: no branch pending.
- WAIT: a branch is held in ID by a hazard.
- SLOT: the next ID instruction is a delay slot.
REQ-009 IDLE transitions:
- Branch with hazard: stall_id = 1 and go to WAIT.
- Branch without hazard: resolve in the same cycle and go to SLOT.
- Jump: pc_sel = 10 and go to SLOT.
REQ-010 WAIT SHALL assert stall_id = 1 and flush_ex = 1 each cycle the hazard persists; it SHALL resolve in the first hazard-free cycle and go to SLOT.
REQ-011 Resolve cycle: pc_sel = 01 if cmp_y else 00; stall_id = 0. Branch latency SHALL be 0 cycles with no hazard and N cycles for N hazard cycles.
REQ-012 in_delay_slot SHALL be 1 exactly while the state is SLOT.
REQ-013 SLOT SHALL return to IDLE on the first cycle with id_valid = 1 and stall_in = 0.
REQ-014 A branch or jump decoded in SLOT SHALL NOT be resolved: pc_sel = 00, ds_branch_err = 1 for that cycle.
REQ-015 While stall_in = 1:
- the state SHALL NOT change;
- counters SHALL NOT increment;
- pc_sel SHALL be 00;
- stall_id and flush_ex SHALL be 0 (the global stall dominates).
REQ-016 Non-branch instructions in IDLE SHALL produce pc_sel = 00, stall_id = 0, flush_ex = 0.
REQ-017 id_valid = 0 SHALL be treated as a non-branch instruction.

Reset
REQ-018 When rst is sampled high, the state SHALL be IDLE and all counters SHALL be 0.
REQ-019 During reset, all combinational outputs SHALL be 0.
REQ-020 Reset in WAIT or SLOT SHALL abandon the pending branch with no redirect.
REQ-021 After reset deasserts, the first instruction SHALL NOT be flagged as a delay slot.

Configuration
REQ-022 With BRANCH_PERF_EN defined, the counters SHALL count on each cycle where stall_in = 0, saturating at 0xFFFFFFFF:
- perf_br: resolved branches.
- perf_taken: branches resolved taken.
- perf_stall: WAIT cycles.
REQ-023 Without BRANCH_PERF_EN, the perf_* ports SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-024 Opcode constants, REGIMM rt codes, pc_sel encodings and FSM state encodings SHALL live in the shared CPU defines package.
REQ-025 Hazard and forward detection (REQ-005 to REQ-007) SHALL be a combinational sub-module named branch_hazard; the FSM and counters SHALL stay in branch_ctrl.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- beq rs=3, rt=4, no hazard, cmp_y = 1 -> pc_sel = 01 in the same cycle; in_delay_slot = 1 on the next instruction; perf_br = 1, perf_taken = 1.
- bne rs=5 with EX writing r5 for 1 cycle, then MEM load writing r5 for 1 cycle -> 2 cycles of stall_id = 1 and flush_ex = 1, then resolve; perf_stall = 2.
- bgez rs=0 with EX writing r0 -> no stall; resolve immediately.
- j in IDLE followed by beq in the delay slot -> pc_sel = 10, then ds_branch_err = 1 and pc_sel = 00.
- Branch in WAIT with stall_in = 1 for 3 cycles -> state held, no counter change; rst pulsed mid-WAIT -> IDLE, all outputs 0.
- With BRANCH_PERF_EN defined and perf_taken preloaded to 0xFFFFFFFF -> a taken branch leaves it at 0xFFFFFFFF; without the macro all perf_* = 0.
